axil_master: RTL and testbench

// AXI4-Lite master (initiator) that turns single register-access commands into AXI-Lite

---
 rtl/axil_master.sv | 167 ++++++++++++++++
 tb/tb_axil_master.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_master.sv
// AXI4-Lite master: turns single valid/ready register commands into AXI-Lite
// write (AW+W->B) or read (AR->R) transactions, one outstanding at a time.
// Ports:
//   m_axi_aclk, m_axi_areset   clock, synchronous active-high reset
//   cmd_*                      command in (valid/ready, we, addr, wdata, wstrb)
//   rsp_*                      response out (valid/ready, we, rdata, resp)
//   m_axi_aw*/w*/b*/ar*/r*     AXI4-Lite master channels
module axil_master #(
  parameter int axil_addr_width = 32,
  parameter int axil_data_width = 32
) (
  input  logic                         m_axi_aclk,
  input  logic                         m_axi_areset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_we,
  input  logic [axil_addr_width-1:0]   cmd_addr,
  input  logic [axil_data_width-1:0]   cmd_wdata,
  input  logic [axil_data_width/8-1:0] cmd_wstrb,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic                         rsp_we,
  output logic [axil_data_width-1:0]   rsp_rdata,
  output logic [1:0]                   rsp_resp,
  output logic                         m_axi_awvalid,
  input  logic                         m_axi_awready,
  output logic [axil_addr_width-1:0]   m_axi_awaddr,
  output logic [2:0]                   m_axi_awprot,
  output logic                         m_axi_wvalid,
  input  logic                         m_axi_wready,
  output logic [axil_data_width-1:0]   m_axi_wdata,
  output logic [axil_data_width/8-1:0] m_axi_wstrb,
  input  logic                         m_axi_bvalid,
  output logic                         m_axi_bready,
  input  logic [1:0]                   m_axi_bresp,
  output logic                         m_axi_arvalid,
  input  logic                         m_axi_arready,
  output logic [axil_addr_width-1:0]   m_axi_araddr,
  output logic [2:0]                   m_axi_arprot,
  input  logic                         m_axi_rvalid,
  output logic                         m_axi_rready,
  input  logic [axil_data_width-1:0]   m_axi_rdata,
  input  logic [1:0]                   m_axi_rresp
);

  typedef enum logic [2:0] {
    IDLE, WR, WB, RA, RR, RSP
  } state_t;

  state_t state, state_d;

  logic [axil_addr_width-1:0]   addr_q;
  logic [axil_data_width-1:0]   wdata_q;
  logic [axil_data_width/8-1:0] wstrb_q;
  logic [axil_data_width-1:0]   rdata_q;
  logic [1:0]                   resp_q;
  logic                         we_q;
  logic                         aw_done;
  logic                         w_done;

  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) state <= IDLE;
    else              state <= state_d;
  end

  // Channel valids/readies are pure decodes of registered state.
  always_comb begin
    state_d       = state;
    cmd_ready     = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    rsp_valid     = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = !m_axi_areset;
        if (cmd_valid && cmd_ready)
          state_d = cmd_we ? WR : RA;
      end
      WR: begin
        m_axi_awvalid = !aw_done;
        m_axi_wvalid  = !w_done;
        // Both may complete in the same cycle or in either order.
        if ((aw_done || m_axi_awready) &&
            (w_done || m_axi_wready))
          state_d = WB;
      end
      WB: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_d = RSP;
      end
      RA: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_d = RR;
      end
      RR: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) state_d = RSP;
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      we_q    <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      rdata_q <= '0;
      resp_q  <= '0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
        we_q    <= cmd_we;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (m_axi_awvalid && m_axi_awready) aw_done <= 1'b1;
      if (m_axi_wvalid && m_axi_wready)   w_done  <= 1'b1;
      if (m_axi_bvalid && m_axi_bready) begin
        resp_q  <= m_axi_bresp;
        rdata_q <= '0;
      end
      if (m_axi_rvalid && m_axi_rready) begin
        resp_q  <= m_axi_rresp;
        rdata_q <= m_axi_rdata;
      end
    end
  end

  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_wdata  = wdata_q;
  assign m_axi_wstrb  = wstrb_q;
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;
  assign rsp_we       = we_q;
  assign rsp_rdata    = rdata_q;
  assign rsp_resp     = resp_q;

  // A raised request valid holds with a stable payload until accepted.
  a_aw_hold: assert property (@(posedge m_axi_aclk)
    disable iff (m_axi_areset)
    m_axi_awvalid && !m_axi_awready |=>
      m_axi_awvalid && $stable(m_axi_awaddr));
  a_w_hold: assert property (@(posedge m_axi_aclk)
    disable iff (m_axi_areset)
    m_axi_wvalid && !m_axi_wready |=>
      m_axi_wvalid && $stable(m_axi_wdata) &&
      $stable(m_axi_wstrb));
  a_ar_hold: assert property (@(posedge m_axi_aclk)
    disable iff (m_axi_areset)
    m_axi_arvalid && !m_axi_arready |=>
      m_axi_arvalid && $stable(m_axi_araddr));

endmodule

// File: tb/tb_axil_master.sv
// Self-checking bench for axil_master: directed vector table, reset and
// back-to-back sequences, then random traffic against a memory model.
module tb_axil_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_we;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_awaddr;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_wvalid, m_axi_wready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_bvalid, m_axi_bready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_arvalid, m_axi_arready;
  logic [31:0] m_axi_araddr;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_rvalid, m_axi_rready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;

  always #5 clk = ~clk;

  axil_master #(
    .axil_addr_width(32),
    .axil_data_width(32)
  ) dut (
    .m_axi_aclk(clk), .m_axi_areset(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_we(rsp_we), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_bresp(m_axi_bresp),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          aw_dly, w_dly, ar_dly, b_dly, r_dly, rsp_dly;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [31:0] slave_mem [16];
  logic [31:0] ref_mem [16];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic vec_t mk(
    input logic we, input logic [31:0] a, input logic [31:0] d,
    input logic [3:0] s, input int awd, input int wd, input int ard,
    input int bd, input int rd, input int sd, input logic [1:0] resp,
    input logic [31:0] rdata, input logic [31:0] erd,
    input logic [1:0] ers);
    vec_t v;
    v.we = we; v.addr = a; v.wdata = d; v.wstrb = s;
    v.aw_dly = awd; v.w_dly = wd; v.ar_dly = ard;
    v.b_dly = bd; v.r_dly = rd; v.rsp_dly = sd;
    v.resp = resp; v.rdata = rdata;
    v.exp_rdata = erd; v.exp_resp = ers;
    return v;
  endfunction

  // Slave-side decode: window 0x100 -> SLVERR, 0x200 -> DECERR.
  function automatic logic [1:0] slave_resp(input logic [31:0] a);
    case (a[9:8])
      2'd1:    return 2'b10;
      2'd2:    return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [31:0] slave_merge(
    input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic run_txn(input vec_t v, input bit use_mem,
                         input bit hold_next, input vec_t nxt);
    int n, exp_lat, mx;
    int aw_w, w_w, ar_w, b_w, r_w, s_w;
    bit aw_h, w_h, ar_h, b_h, r_h, pa, pw, pr, seen, done;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  s_resp;
    logic        s_we;
    aw_w = 0; w_w = 0; ar_w = 0; b_w = 0; r_w = 0; s_w = 0;
    aw_h = 0; w_h = 0; ar_h = 0; b_h = 0; r_h = 0;
    seen = 0; done = 0;
    s_addr = '0; s_wdata = '0; s_wstrb = '0;
    s_rdata = '0; s_resp = '0; s_we = 1'b0;
    mx = (v.aw_dly > v.w_dly) ? v.aw_dly : v.w_dly;
    exp_lat = v.we ? 3 + mx + v.b_dly : 3 + v.ar_dly + v.r_dly;
    cmd_valid = 1'b1; cmd_we = v.we; cmd_addr = v.addr;
    cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (cmd_ready !== 1'b1) begin
      chk("cmd_accept_timeout", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    for (int k = 1; k <= 300 && !done; k++) begin
      @(negedge clk);
      if (k == 1) cmd_valid = 1'b0;
      m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
      m_axi_bvalid = 0; m_axi_rvalid = 0; rsp_ready = 0;
      pa = aw_h; pw = w_h; pr = ar_h;
      chk("awvalid", {31'd0, m_axi_awvalid}, {31'd0, v.we && !aw_h});
      chk("wvalid", {31'd0, m_axi_wvalid}, {31'd0, v.we && !w_h});
      chk("arvalid", {31'd0, m_axi_arvalid}, {31'd0, !v.we && !ar_h});
      chk("bready", {31'd0, m_axi_bready},
          {31'd0, v.we && aw_h && w_h && !b_h});
      chk("rready", {31'd0, m_axi_rready},
          {31'd0, !v.we && ar_h && !r_h});
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, b_h || r_h});
      chk("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
      if (m_axi_awvalid && !aw_h) begin
        chk("awaddr", m_axi_awaddr, v.addr);
        chk("awprot", {29'd0, m_axi_awprot}, 32'd0);
        if (aw_w == v.aw_dly) begin
          m_axi_awready = 1; aw_h = 1; s_addr = m_axi_awaddr;
        end else aw_w++;
      end
      if (m_axi_wvalid && !w_h) begin
        chk("wdata", m_axi_wdata, v.wdata);
        chk("wstrb", {28'd0, m_axi_wstrb}, {28'd0, v.wstrb});
        if (w_w == v.w_dly) begin
          m_axi_wready = 1; w_h = 1;
          s_wdata = m_axi_wdata; s_wstrb = m_axi_wstrb;
        end else w_w++;
      end
      if (v.we && pa && pw && !b_h) begin
        if (b_w == v.b_dly) begin
          m_axi_bvalid = 1; b_h = 1;
          if (use_mem) begin
            m_axi_bresp = slave_resp(s_addr);
            if (m_axi_bresp == 2'b00)
              slave_mem[s_addr[5:2]] =
                slave_merge(slave_mem[s_addr[5:2]], s_wdata, s_wstrb);
          end else m_axi_bresp = v.resp;
        end else b_w++;
      end
      if (m_axi_arvalid && !ar_h) begin
        chk("araddr", m_axi_araddr, v.addr);
        chk("arprot", {29'd0, m_axi_arprot}, 32'd0);
        if (ar_w == v.ar_dly) begin
          m_axi_arready = 1; ar_h = 1; s_addr = m_axi_araddr;
        end else ar_w++;
      end
      if (!v.we && pr && !r_h) begin
        if (r_w == v.r_dly) begin
          m_axi_rvalid = 1; r_h = 1;
          if (use_mem) begin
            m_axi_rresp = slave_resp(s_addr);
            m_axi_rdata = (m_axi_rresp == 2'b00) ?
              slave_mem[s_addr[5:2]] : 32'hBADBAD00;
          end else begin
            m_axi_rresp = v.resp;
            m_axi_rdata = v.rdata;
          end
        end else r_w++;
      end
      if (rsp_valid) begin
        if (!seen) begin
          seen = 1;
          s_we = rsp_we; s_rdata = rsp_rdata; s_resp = rsp_resp;
          chk("latency", k, exp_lat);
          chk("rsp_we", {31'd0, rsp_we}, {31'd0, v.we});
          chk("rsp_rdata", rsp_rdata, v.exp_rdata);
          chk("rsp_resp", {30'd0, rsp_resp}, {30'd0, v.exp_resp});
        end else begin
          chk("rsp_we_stable", {31'd0, rsp_we}, {31'd0, s_we});
          chk("rsp_rdata_stable", rsp_rdata, s_rdata);
          chk("rsp_resp_stable", {30'd0, rsp_resp}, {30'd0, s_resp});
        end
        if (hold_next) begin
          cmd_valid = 1'b1; cmd_we = nxt.we; cmd_addr = nxt.addr;
          cmd_wdata = nxt.wdata; cmd_wstrb = nxt.wstrb;
        end
        if (s_w == v.rsp_dly) begin
          rsp_ready = 1; done = 1;
        end else s_w++;
      end
    end
    if (!done) chk("txn_timeout", 32'd0, 32'd1);
    @(negedge clk);
    rsp_ready = 0;
    chk("cmd_ready_after_rsp", {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    vec_t tbl [7];
    vec_t v;
    int sel, idx;
    logic [31:0] a, d, mask;
    logic [3:0] s;
    logic [1:0] er;
    logic we;
    rst = 1; cmd_valid = 0; cmd_we = 0; cmd_addr = 0;
    cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
    m_axi_bvalid = 0; m_axi_bresp = 0;
    m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
    for (int i = 0; i < 16; i++) begin
      slave_mem[i] = 32'h5A000000 + i * 32'h00010101;
      ref_mem[i] = slave_mem[i];
    end
    tbl[0] = mk(1, 'h10, 'hDEADBEEF, 'hF, 0, 0, 0, 0, 0, 0,
                2'b00, 0, 0, 2'b00);
    tbl[1] = mk(1, 'h14, 'hCAFEF00D, 'h3, 3, 0, 0, 1, 0, 0,
                2'b00, 0, 0, 2'b00);
    tbl[2] = mk(0, 'h20, 0, 0, 0, 0, 2, 0, 4, 0,
                2'b10, 'h12345678, 'h12345678, 2'b10);
    tbl[3] = mk(1, 'h08, 'h11223344, 'hC, 0, 2, 0, 0, 0, 5,
                2'b11, 0, 0, 2'b11);
    tbl[4] = mk(0, 'h30, 0, 0, 0, 0, 0, 1, 0, 0,
                2'b00, 'h0BADF00D, 'h0BADF00D, 2'b00);
    tbl[5] = mk(1, 'h04, 'hA5A55A5A, 'hF, 1, 1, 0, 0, 0, 0,
                2'b00, 0, 0, 2'b00);
    tbl[6] = mk(0, 'h04, 0, 0, 0, 0, 0, 0, 0, 1,
                2'b00, 'hA5A55A5A, 'hA5A55A5A, 2'b00);

    repeat (3) @(negedge clk);
    chk("rst_awvalid", {31'd0, m_axi_awvalid}, 32'd0);
    chk("rst_wvalid", {31'd0, m_axi_wvalid}, 32'd0);
    chk("rst_arvalid", {31'd0, m_axi_arvalid}, 32'd0);
    chk("rst_bready", {31'd0, m_axi_bready}, 32'd0);
    chk("rst_rready", {31'd0, m_axi_rready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_awaddr", m_axi_awaddr, 32'd0);
    chk("rst_wdata", m_axi_wdata, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_resp", {30'd0, rsp_resp}, 32'd0);
    rst = 0;
    #1;
    chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      bit hold;
      hold = (i == 3) || (i == 5);
      run_txn(tbl[i], 0, hold, (i < 6) ? tbl[i+1] : tbl[i]);
    end

    // Reset while waiting for B: transfer abandoned, late B ignored.
    cmd_valid = 1; cmd_we = 1; cmd_addr = 32'h18;
    cmd_wdata = 32'h01020304; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 0; m_axi_awready = 1; m_axi_wready = 1;
    chk("mid_awvalid", {31'd0, m_axi_awvalid}, 32'd1);
    @(negedge clk);
    m_axi_awready = 0; m_axi_wready = 0;
    chk("mid_bready", {31'd0, m_axi_bready}, 32'd1);
    rst = 1;
    @(negedge clk);
    chk("mid_rst_bready", {31'd0, m_axi_bready}, 32'd0);
    chk("mid_rst_awvalid", {31'd0, m_axi_awvalid}, 32'd0);
    chk("mid_rst_wvalid", {31'd0, m_axi_wvalid}, 32'd0);
    chk("mid_rst_arvalid", {31'd0, m_axi_arvalid}, 32'd0);
    chk("mid_rst_rready", {31'd0, m_axi_rready}, 32'd0);
    chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    rst = 0; m_axi_bvalid = 1; m_axi_bresp = 2'b10;
    #1;
    chk("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    chk("late_b_bready", {31'd0, m_axi_bready}, 32'd0);
    chk("late_b_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("late_b_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    m_axi_bvalid = 0;
    run_txn(tbl[0], 0, 0, tbl[0]);

    // Random traffic; the model works purely at command level.
    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 5);
      idx = $urandom_range(0, 15);
      a = (sel == 4 ? 32'h100 : sel == 5 ? 32'h200 : 32'h0) + idx * 4;
      we = 1'($urandom_range(0, 1));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      er = (a >= 32'h200) ? 2'b11 : (a >= 32'h100) ? 2'b10 : 2'b00;
      v = mk(we, a, d, s,
             $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 2),
             2'b00, 0,
             we ? 32'd0 : (er == 2'b00 ? ref_mem[idx] : 32'hBADBAD00),
             er);
      run_txn(v, 1, 0, v);
      if (we && er == 2'b00) begin
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        ref_mem[idx] = (ref_mem[idx] & ~mask) | (d & mask);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
